// File: rtl/generador_movimiento.sv
// generador_movimiento
//   Producer side of the 3-bit movement-code interface. It turns four raw push-buttons
//   into one debounced movement command per physical press. The command is held on a
//   valid/ready handshake until the board/score logic accepts it.
//
//   State table
//     state          | meaning
//     S_IDLE         | waiting for a press while enable=1
//     S_DEBOUNCE     | latched button must stay pressed DEBOUNCE_CYCLES cycles
//     S_ISSUE        | command presented, held until mov_valid & mov_ready
//     S_WAIT_RELEASE | all buttons must stay released DEBOUNCE_CYCLES cycles
//
//   Ports
//     clk                      system clock, rising edge
//     rst                      synchronous reset, active-high
//     btn_izq/der/arr/aba      raw buttons, asynchronous to clk
//     enable                   1 = new presses may be accepted
//     mov_ready                consumer accepts the code this cycle
//     movimiento[2:0]          000 quieto, 001 izq, 010 der, 011 arr, 100 aba
//     mov_valid                movimiento holds a command awaiting acceptance
module generador_movimiento #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arr,
    input  logic       btn_aba,
    input  logic       enable,
    input  logic       mov_ready,
    output logic [2:0] movimiento,
    output logic       mov_valid
);

    localparam int unsigned    CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  C_TC  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  C_MAX = CW'(DEBOUNCE_CYCLES);
    // Raw level of a released button; the synchronizers reset to this value.
    localparam logic [3:0]     C_REL = {4{BTN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_ISSUE,
        S_WAIT_RELEASE
    } state_t;

    logic [3:0]    r_sync1, r_sync2;
    logic [3:0]    w_pressed;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [2:0]    r_sel, w_sel_next, w_prio;
    logic          w_sel_held;
    logic          r_mov_valid;
    logic [2:0]    r_mov;

    // Bit order {aba, arr, der, izq}; pressed=1 after normalisation.
    assign w_pressed = r_sync2 ^ C_REL;
    assign w_cnt_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + CW'(1);

    always_comb begin
        w_prio = 3'd0;
        if (w_pressed[0])      w_prio = 3'd1;
        else if (w_pressed[1]) w_prio = 3'd2;
        else if (w_pressed[2]) w_prio = 3'd3;
        else if (w_pressed[3]) w_prio = 3'd4;
    end

    always_comb begin
        case (r_sel)
            3'd1:    w_sel_held = w_pressed[0];
            3'd2:    w_sel_held = w_pressed[1];
            3'd3:    w_sel_held = w_pressed[2];
            3'd4:    w_sel_held = w_pressed[3];
            default: w_sel_held = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_sel_next = r_sel;
        case (r_state)
            S_IDLE: begin
                if ((|w_pressed) && enable) begin
                    w_next     = S_DEBOUNCE;
                    w_sel_next = w_prio;
                    w_cnt_next = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!w_sel_held) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == C_TC) begin
                    w_next     = S_ISSUE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_ISSUE: begin
                if (r_mov_valid && mov_ready) begin
                    w_next     = S_WAIT_RELEASE;
                    w_cnt_next = '0;
                end
            end
            S_WAIT_RELEASE: begin
                if (|w_pressed) begin
                    w_cnt_next = '0;
                end else if (r_cnt == C_TC) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= C_REL;
            r_sync2     <= C_REL;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= 3'd0;
            r_mov_valid <= 1'b0;
            r_mov       <= 3'd0;
        end else begin
            r_sync1     <= {btn_aba, btn_arr, btn_der, btn_izq};
            r_sync2     <= r_sync1;
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_sel       <= w_sel_next;
            // Outputs are flopped from the next state so they change on the same
            // edge as the state register and never glitch.
            r_mov_valid <= (w_next == S_ISSUE);
            r_mov       <= (w_next == S_ISSUE) ? w_sel_next : 3'd0;
        end
    end

    assign mov_valid  = r_mov_valid;
    assign movimiento = r_mov;

endmodule
